sram_timing_ctrl: RTL and testbench
===================================

Name: sram_timing_ctrl

Overview:
- Parametrised SRAM macro sequencer, next generation of the fixed 3-cycle control FSM.
- Accepts read/write requests over a valid/ready handshake and latches address, write data and operation type at acceptance.
- Drives precharge, wordline, column, sense and write-driver enables with per-phase cycle counts set by parameters.
- Captures sense-amp data into a registered read port with a valid pulse. Sits between the host interface and the bitcell array/periphery.

Parameters:
- ADDR_W, 6, request address width.
- DATA_W, 8, data width.
- PRECHARGE_CYCLES, 1, cycles in PRECHARGE (>=1).
- DEVELOP_CYCLES, 1, cycles in DEVELOP (>=1).
- READ_CYCLES, 1, cycles in ACCESS for reads (>=1).
- WRITE_CYCLES, 1, cycles in ACCESS for writes (>=1).
- WRITE_SKIP_DEVELOP, 0, 1 = writes go PRECHARGE -> ACCESS directly.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_rnw  in  1  1=read, 0=write.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- addr_q  out  ADDR_W  latched address to row/col decoders.
- wdata_q  out  DATA_W  latched data to write drivers.
- sense_data  in  DATA_W  sense-amp outputs.
- rdata  out  DATA_W  registered read data.
- rdata_valid  out  1  one-cycle pulse, rdata valid.
- precharge_enable  out  1  P/EQ on.
- row_enable  out  1  wordline enable.
- col_enable  out  1  column decoder enable.
- read_enable  out  1  sense amps / column mux on.
- write_enable  out  1  write drivers on.
- busy  out  1  operation in flight (state != IDLE).

Behaviour:
- Clock is `clk`; reset is `rst`, synchronous and active-high. `rst` is sampled only on the rising edge of `clk`.
- States: IDLE, PRECHARGE, DEVELOP, ACCESS. A single phase counter, sized for the largest cycle parameter, is loaded on every state entry.
- Reset, at any time including mid-operation: state=IDLE, counter=0, addr_q=0, wdata_q=0, rdata=0, rdata_valid=0, latched rnw=1. Any in-flight operation is abandoned with no write_enable/read_enable glitch after the reset edge.
- Control outputs are decoded from the registered state only (glitch-free per state):
  - IDLE: precharge_enable=1, req_ready=1, all other enables 0.
  - PRECHARGE: precharge_enable=1, col_enable=1.
  - DEVELOP: row_enable=1, col_enable=1.
  - ACCESS: row_enable=1, col_enable=1, plus read_enable=rnw_q or write_enable=!rnw_q.
  - precharge_enable and row_enable are never both 1.
- req_ready=1 in IDLE, and in the final cycle of ACCESS (back-to-back issue); 0 otherwise.
- Handshake: acceptance = req_valid && req_ready.
  - On acceptance, rnw_q/addr_q/wdata_q load from the request and the next state is PRECHARGE.
  - Latched values hold until the next acceptance; request inputs are ignored otherwise.
- Transitions (cycle counts exact):
  - IDLE -> PRECHARGE on acceptance, else stay in IDLE.
  - PRECHARGE -> DEVELOP after PRECHARGE_CYCLES. If WRITE_SKIP_DEVELOP=1 and rnw_q=0, go directly to ACCESS instead.
  - DEVELOP -> ACCESS after DEVELOP_CYCLES.
  - ACCESS lasts READ_CYCLES (read) or WRITE_CYCLES (write). After its final cycle: PRECHARGE if a request was accepted in that cycle, else IDLE.
- Read capture: on the edge ending the final ACCESS cycle of a read, rdata <= sense_data.
  - rdata_valid=1 for exactly the following cycle.
  - rdata holds its value until the next read capture.
  - Writes never pulse rdata_valid or change rdata.
- Read latency, with acceptance in cycle 0: rdata_valid is asserted in cycle PRECHARGE_CYCLES + DEVELOP_CYCLES + READ_CYCLES + 1.
- Back-to-back throughput: one operation per P+D+A cycles, where P = PRECHARGE_CYCLES, D = DEVELOP_CYCLES (0 for skipped writes) and A = the ACCESS length. No idle cycle is inserted between operations.
- An rdata_valid pulse coinciding with the next operation's PRECHARGE is legal.
- busy = (state != IDLE).

Test Plan:
- Defaults, single read, addr=0x15, sense_data=0xA5 -> PRECHARGE/DEVELOP/ACCESS each 1 cycle; read_enable high 1 cycle; rdata=0xA5 with rdata_valid in cycle 4; back to IDLE, precharge_enable=1.
- PRECHARGE_CYCLES=2, DEVELOP_CYCLES=3, WRITE_CYCLES=2, write addr=0x3F data=0x5A -> precharge 2 cycles, row_enable 5 cycles, write_enable 2 cycles with addr_q=0x3F, wdata_q=0x5A; no rdata_valid.
- Defaults, req_valid held high with read, write, read -> operations complete every 3 cycles with no IDLE; req_ready high only in ACCESS cycles; each op uses its own latched rnw/addr.
- req_rnw and req_addr toggled mid-operation -> no effect on write_enable/read_enable or addr_q until the next acceptance.
- WRITE_SKIP_DEVELOP=1: write takes 2 cycles (PRECHARGE -> ACCESS); read still takes 3 cycles including DEVELOP.
- rst asserted during DEVELOP -> next cycle IDLE, row_enable=0, precharge_enable=1, addr_q=0, rdata_valid=0; a new request is accepted normally after rst drops.

Source files
------------

// File: rtl/sram_timing_ctrl.sv
// SRAM macro sequencer: valid/ready request intake, per-phase timed enables
// for precharge/develop/access, and a registered read port with a valid pulse.
module sram_timing_ctrl #(
    parameter int unsigned ADDR_W             = 6,
    parameter int unsigned DATA_W             = 8,
    parameter int unsigned PRECHARGE_CYCLES   = 1,
    parameter int unsigned DEVELOP_CYCLES     = 1,
    parameter int unsigned READ_CYCLES        = 1,
    parameter int unsigned WRITE_CYCLES       = 1,
    parameter int unsigned WRITE_SKIP_DEVELOP = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rnw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] addr_q,
    output logic [DATA_W-1:0] wdata_q,
    input  logic [DATA_W-1:0] sense_data,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              precharge_enable,
    output logic              row_enable,
    output logic              col_enable,
    output logic              read_enable,
    output logic              write_enable,
    output logic              busy
);

    localparam int unsigned MAX_PD  = (PRECHARGE_CYCLES > DEVELOP_CYCLES) ? PRECHARGE_CYCLES : DEVELOP_CYCLES;
    localparam int unsigned MAX_RW  = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_PD > MAX_RW) ? MAX_PD : MAX_RW;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Counter loads (cycles - 1) on state entry and counts down to zero.
    localparam logic [CNT_W-1:0] P_LOAD = CNT_W'(PRECHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] D_LOAD = CNT_W'(DEVELOP_CYCLES - 1);
    localparam logic [CNT_W-1:0] R_LOAD = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] W_LOAD = CNT_W'(WRITE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRECHARGE = 2'd1,
        DEVELOP   = 2'd2,
        ACCESS    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             rnw_q;
    logic             rnw_d;
    logic             accept;
    logic             last;
    logic             capture;

    assign accept  = req_valid && req_ready;
    assign last    = (cnt == '0);
    assign capture = (state == ACCESS) && last && rnw_q;
    assign rnw_d   = accept ? req_rnw : rnw_q;

    // Next-state and phase-counter logic.
    always_comb begin
        state_d = state;
        cnt_d   = last ? cnt : cnt - CNT_W'(1);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = PRECHARGE;
                    cnt_d   = P_LOAD;
                end
            end
            PRECHARGE: begin
                if (last) begin
                    if ((WRITE_SKIP_DEVELOP != 0) && !rnw_q) begin
                        state_d = ACCESS;
                        cnt_d   = W_LOAD;
                    end else begin
                        state_d = DEVELOP;
                        cnt_d   = D_LOAD;
                    end
                end
            end
            DEVELOP: begin
                if (last) begin
                    state_d = ACCESS;
                    cnt_d   = rnw_q ? R_LOAD : W_LOAD;
                end
            end
            ACCESS: begin
                if (last) begin
                    if (accept) begin
                        state_d = PRECHARGE;
                        cnt_d   = P_LOAD;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, latches and control outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            rnw_q            <= 1'b1;
            addr_q           <= '0;
            wdata_q          <= '0;
            rdata            <= '0;
            rdata_valid      <= 1'b0;
            precharge_enable <= 1'b1;
            req_ready        <= 1'b1;
            row_enable       <= 1'b0;
            col_enable       <= 1'b0;
            read_enable      <= 1'b0;
            write_enable     <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            rnw_q <= rnw_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (capture) begin
                rdata <= sense_data;
            end
            rdata_valid      <= capture;
            precharge_enable <= (state_d == IDLE) || (state_d == PRECHARGE);
            row_enable       <= (state_d == DEVELOP) || (state_d == ACCESS);
            col_enable       <= (state_d != IDLE);
            read_enable      <= (state_d == ACCESS) && rnw_d;
            write_enable     <= (state_d == ACCESS) && !rnw_d;
            req_ready        <= (state_d == IDLE) || ((state_d == ACCESS) && (cnt_d == '0));
            busy             <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_sram_timing_ctrl.sv
// Directed bench for sram_timing_ctrl: default, long-phase and skip-develop
// configurations share stimulus; each test reads the instance it targets.
module tb_sram_timing_ctrl;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 8;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_rnw;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] sense_data;

    logic          req_ready   [NI];
    logic [AW-1:0] addr_q      [NI];
    logic [DW-1:0] wdata_q     [NI];
    logic [DW-1:0] rdata       [NI];
    logic          rdata_valid [NI];
    logic          pre_en      [NI];
    logic          row_en      [NI];
    logic          col_en      [NI];
    logic          rd_en       [NI];
    logic          wr_en       [NI];
    logic          busy        [NI];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sram_timing_ctrl u_def (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata),
        .addr_q(addr_q[0]), .wdata_q(wdata_q[0]), .sense_data(sense_data),
        .rdata(rdata[0]), .rdata_valid(rdata_valid[0]), .precharge_enable(pre_en[0]),
        .row_enable(row_en[0]), .col_enable(col_en[0]), .read_enable(rd_en[0]),
        .write_enable(wr_en[0]), .busy(busy[0])
    );

    sram_timing_ctrl #(
        .PRECHARGE_CYCLES(2), .DEVELOP_CYCLES(3), .WRITE_CYCLES(2)
    ) u_lng (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata),
        .addr_q(addr_q[1]), .wdata_q(wdata_q[1]), .sense_data(sense_data),
        .rdata(rdata[1]), .rdata_valid(rdata_valid[1]), .precharge_enable(pre_en[1]),
        .row_enable(row_en[1]), .col_enable(col_en[1]), .read_enable(rd_en[1]),
        .write_enable(wr_en[1]), .busy(busy[1])
    );

    sram_timing_ctrl #(
        .WRITE_SKIP_DEVELOP(1)
    ) u_skp (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[2]),
        .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata),
        .addr_q(addr_q[2]), .wdata_q(wdata_q[2]), .sense_data(sense_data),
        .rdata(rdata[2]), .rdata_valid(rdata_valid[2]), .precharge_enable(pre_en[2]),
        .row_enable(row_en[2]), .col_enable(col_en[2]), .read_enable(rd_en[2]),
        .write_enable(wr_en[2]), .busy(busy[2])
    );

    // Packed view {pre, ready, row, col, rd, wr, busy, rvld} of one instance.
    function automatic logic [7:0] ctl(input int i);
        return {pre_en[i], req_ready[i], row_en[i], col_en[i],
                rd_en[i], wr_en[i], busy[i], rdata_valid[i]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_rnw = 1'b1; req_addr = '0; req_wdata = '0; sense_data = '0;
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            n_chk++;
            if (ctl(i) !== 8'hC0) $display("FAIL reset_ctl[%0d] got %h exp c0", i, ctl(i));
            else n_pass++;
            n_chk++;
            if ({addr_q[i], wdata_q[i], rdata[i]} !== '0)
                $display("FAIL reset_regs[%0d] got %h/%h/%h exp 0", i, addr_q[i], wdata_q[i], rdata[i]);
            else n_pass++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        logic [7:0] exp_ctl [6] = '{8'hC0, 8'h92, 8'h32, 8'h7A, 8'hC1, 8'hC0};
        do_reset();
        req_valid = 1'b1; req_rnw = 1'b1; req_addr = 6'h15; req_wdata = 8'h00; sense_data = 8'hA5;
        for (int c = 0; c < 6; c++) begin
            n_chk++;
            if (ctl(0) !== exp_ctl[c]) $display("FAIL single_read_ctl c%0d got %h exp %h", c, ctl(0), exp_ctl[c]);
            else n_pass++;
            if (c == 3) begin
                n_chk++;
                if (addr_q[0] !== 6'h15) $display("FAIL single_read_addr got %h exp 15", addr_q[0]);
                else n_pass++;
            end
            if (c >= 4) begin
                n_chk++;
                if (rdata[0] !== 8'hA5) $display("FAIL single_read_rdata c%0d got %h exp a5", c, rdata[0]);
                else n_pass++;
            end
            tick();
            req_valid = 1'b0;
        end
    endtask

    task automatic test_long_write();
        int n_pre = 0, n_row = 0, n_wr = 0, n_rv = 0, n_busy = 0;
        do_reset();
        req_valid = 1'b1; req_rnw = 1'b0; req_addr = 6'h3F; req_wdata = 8'h5A;
        tick();
        req_valid = 1'b0; req_addr = 6'h00; req_wdata = 8'h00;
        for (int c = 1; c <= 12; c++) begin
            if (busy[1]) n_busy++;
            if (busy[1] && pre_en[1]) n_pre++;
            if (row_en[1]) n_row++;
            if (rdata_valid[1]) n_rv++;
            if (wr_en[1]) begin
                n_wr++;
                n_chk++;
                if ({addr_q[1], wdata_q[1]} !== {6'h3F, 8'h5A})
                    $display("FAIL long_write_latch c%0d got %h/%h exp 3f/5a", c, addr_q[1], wdata_q[1]);
                else n_pass++;
            end
            tick();
        end
        n_chk++;
        if ({n_busy, n_pre, n_row, n_wr, n_rv} !== {32'd7, 32'd2, 32'd5, 32'd2, 32'd0})
            $display("FAIL long_write_counts busy=%0d pre=%0d row=%0d wr=%0d rv=%0d exp 7/2/5/2/0",
                     n_busy, n_pre, n_row, n_wr, n_rv);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0]    exp_ctl  [10] = '{8'h92, 8'h32, 8'h7A, 8'h93, 8'h32, 8'h76, 8'h92, 8'h32, 8'h7A, 8'hC1};
        logic [AW-1:0] exp_addr [10] = '{6'h01, 6'h01, 6'h01, 6'h02, 6'h02, 6'h02, 6'h03, 6'h03, 6'h03, 6'h03};
        do_reset();
        req_valid = 1'b1; req_rnw = 1'b1; req_addr = 6'h01; req_wdata = 8'hAA; sense_data = 8'h11;
        tick();
        for (int c = 1; c <= 10; c++) begin
            if (c == 1) begin req_rnw = 1'b0; req_addr = 6'h02; req_wdata = 8'hBB; end
            if (c == 4) begin req_rnw = 1'b1; req_addr = 6'h03; req_wdata = 8'hCC; end
            if (c == 5) sense_data = 8'h22;
            if (c == 7) req_valid = 1'b0;
            n_chk++;
            if (ctl(0) !== exp_ctl[c-1] || addr_q[0] !== exp_addr[c-1])
                $display("FAIL b2b c%0d got ctl %h addr %h exp %h %h", c, ctl(0), addr_q[0], exp_ctl[c-1], exp_addr[c-1]);
            else n_pass++;
            if (c == 4 || c == 7 || c == 10) begin
                n_chk++;
                if (rdata[0] !== ((c == 10) ? 8'h22 : 8'h11))
                    $display("FAIL b2b_rdata c%0d got %h exp %h", c, rdata[0], (c == 10) ? 8'h22 : 8'h11);
                else n_pass++;
            end
            if (c == 6) begin
                n_chk++;
                if (wdata_q[0] !== 8'hBB) $display("FAIL b2b_wdata got %h exp bb", wdata_q[0]);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_hold_inputs();
        do_reset();
        req_valid = 1'b1; req_rnw = 1'b0; req_addr = 6'h2A; req_wdata = 8'h33;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            req_rnw   = c[0];
            req_addr  = 6'(c * 13);
            req_wdata = 8'(c * 37);
            n_chk++;
            if ({addr_q[0], wdata_q[0]} !== {6'h2A, 8'h33})
                $display("FAIL hold_latch c%0d got %h/%h exp 2a/33", c, addr_q[0], wdata_q[0]);
            else n_pass++;
            if (c == 3) begin
                n_chk++;
                if (ctl(0) !== 8'h76) $display("FAIL hold_access_ctl got %h exp 76", ctl(0));
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_skip_develop();
        logic [7:0] exp_w [3] = '{8'h92, 8'h76, 8'hC0};
        logic [7:0] exp_r [4] = '{8'h92, 8'h32, 8'h7A, 8'hC1};
        do_reset();
        req_valid = 1'b1; req_rnw = 1'b0; req_addr = 6'h11; req_wdata = 8'h44;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            n_chk++;
            if (ctl(2) !== exp_w[c-1]) $display("FAIL skip_write c%0d got %h exp %h", c, ctl(2), exp_w[c-1]);
            else n_pass++;
            tick();
        end
        req_valid = 1'b1; req_rnw = 1'b1; req_addr = 6'h12; sense_data = 8'h5C;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            n_chk++;
            if (ctl(2) !== exp_r[c-1]) $display("FAIL skip_read c%0d got %h exp %h", c, ctl(2), exp_r[c-1]);
            else n_pass++;
            tick();
        end
        n_chk++;
        if (rdata[2] !== 8'h5C) $display("FAIL skip_read_rdata got %h exp 5c", rdata[2]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        req_valid = 1'b1; req_rnw = 1'b1; req_addr = 6'h2B; sense_data = 8'h77;
        tick();
        req_valid = 1'b0;
        tick();
        n_chk++;
        if (ctl(0) !== 8'h32) $display("FAIL rst_mid_develop got %h exp 32", ctl(0));
        else n_pass++;
        rst = 1'b1;
        tick();
        n_chk++;
        if (ctl(0) !== 8'hC0 || addr_q[0] !== 6'h00)
            $display("FAIL rst_mid_after got ctl %h addr %h exp c0 00", ctl(0), addr_q[0]);
        else n_pass++;
        rst = 1'b0;
        req_valid = 1'b1; req_rnw = 1'b1; req_addr = 6'h07; sense_data = 8'h3C;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        n_chk++;
        if (ctl(0) !== 8'hC1 || rdata[0] !== 8'h3C || addr_q[0] !== 6'h07)
            $display("FAIL rst_mid_reissue got ctl %h rdata %h addr %h exp c1 3c 07", ctl(0), rdata[0], addr_q[0]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_long_write();
        test_back_to_back();
        test_hold_inputs();
        test_skip_develop();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
